// File: rtl/mem_access_unit.sv
// mem_access_unit: memory pipeline stage; runs load/store bus transfers with req/ack,
// aligns and extends load data, and registers the write-back request.
// Ports: ex_* EX/MEM instruction in; bus_* data bus handshake; stall_req_o holds upstream;
// mem_w_reg_* registered write-back; fault_o / timeout_o one-cycle error pulses.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic        ex_mem_rd_i,
  input  logic        ex_mem_wr_i,
  input  logic [2:0]  ex_mem_op_i,
  input  logic [31:0] ex_mem_addr_i,
  input  logic [31:0] ex_mem_wdata_i,
  input  logic        ex_w_reg_req_i,
  input  logic [4:0]  ex_w_reg_addr_i,
  input  logic [31:0] ex_w_reg_data_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_req_o,
  output logic        mem_w_reg_req_o,
  output logic [4:0]  mem_w_reg_addr_o,
  output logic [31:0] mem_w_reg_data_o,
  output logic        fault_o,
  output logic        timeout_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  op;
  logic [1:0]  lo;
  logic        l_req;
  logic [4:0]  l_rd;
  logic        is_mem, bad, last;
  logic [3:0]  be;
  logic [31:0] wdata, ext;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    is_mem = ex_mem_rd_i | ex_mem_wr_i;
    // illegal funct3 011/110/111, misaligned half/word, or both directions at once
    bad = (ex_mem_rd_i & ex_mem_wr_i) | (ex_mem_op_i[1:0] == 2'b11) | (ex_mem_op_i[2] & ex_mem_op_i[1])
        | ((ex_mem_op_i[1:0] == 2'b01) & ex_mem_addr_i[0])
        | ((ex_mem_op_i == 3'b010) & (|ex_mem_addr_i[1:0]));
    be = ex_mem_op_i[1] ? 4'b1111 : ex_mem_op_i[0] ? (ex_mem_addr_i[1] ? 4'b1100 : 4'b0011)
       : 4'b0001 << ex_mem_addr_i[1:0];
    wdata = ex_mem_op_i[1] ? ex_mem_wdata_i : ex_mem_op_i[0] ? {2{ex_mem_wdata_i[15:0]}}
          : {4{ex_mem_wdata_i[7:0]}};
    last = cnt == 8'(TIMEOUT - 1);
    b = bus_rdata_i[{lo, 3'b000} +: 8];
    h = bus_rdata_i[{lo[1], 4'b0000} +: 16];
    // op[2] selects zero extension
    ext = op[1] ? bus_rdata_i : op[0] ? {{16{~op[2] & h[15]}}, h} : {{24{~op[2] & b[7]}}, b};
    stall_req_o = rst_n & (state == IDLE ? ex_valid_i & is_mem & ~bad : ~bus_ack_i & ~last);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      lo <= '0;
      l_req <= 1'b0;
      l_rd <= '0;
      bus_req_o <= 1'b0;
      bus_we_o <= 1'b0;
      bus_addr_o <= '0;
      bus_be_o <= '0;
      bus_wdata_o <= '0;
      mem_w_reg_req_o <= 1'b0;
      mem_w_reg_addr_o <= '0;
      mem_w_reg_data_o <= '0;
      fault_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      fault_o <= 1'b0;
      timeout_o <= 1'b0;
      if (state == IDLE) begin
        if (ex_valid_i && is_mem) begin
          mem_w_reg_req_o <= 1'b0;
          if (bad) fault_o <= 1'b1;
          else begin
            state <= BUSY;
            cnt <= '0;
            op <= ex_mem_op_i;
            lo <= ex_mem_addr_i[1:0];
            l_req <= ex_w_reg_req_i;
            l_rd <= ex_w_reg_addr_i;
            bus_req_o <= 1'b1;
            bus_we_o <= ex_mem_wr_i;
            bus_addr_o <= {ex_mem_addr_i[31:2], 2'b00};
            bus_be_o <= be;
            bus_wdata_o <= wdata;
          end
        end else if (ex_valid_i) begin
          mem_w_reg_req_o <= ex_w_reg_req_i;
          mem_w_reg_addr_o <= ex_w_reg_addr_i;
          mem_w_reg_data_o <= ex_w_reg_data_i;
        end else mem_w_reg_req_o <= 1'b0;
      end else if (bus_ack_i) begin
        state <= IDLE;
        bus_req_o <= 1'b0;
        mem_w_reg_req_o <= ~bus_we_o & l_req;
        if (!bus_we_o) begin
          mem_w_reg_addr_o <= l_rd;
          mem_w_reg_data_o <= ext;
        end
      end else if (last) begin
        state <= IDLE;
        bus_req_o <= 1'b0;
        timeout_o <= 1'b1;
      end else cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven check of mem_access_unit with TIMEOUT = 4.
module tb_mem_access_unit;
  logic        clk = 0, rst_n = 0;
  logic        ex_valid = 0, ex_rd = 0, ex_wr = 0;
  logic [2:0]  ex_op = 0;
  logic [31:0] ex_addr = 0, ex_wdata = 0;
  logic        ex_wreq = 0;
  logic [4:0]  ex_wrd = 0;
  logic [31:0] ex_wdat = 0;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 0;
  logic [31:0] bus_rdata = 0;
  logic        stall, wreq, fault, tmo;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  int checks = 0, fails = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_mem_rd_i(ex_rd), .ex_mem_wr_i(ex_wr),
    .ex_mem_op_i(ex_op), .ex_mem_addr_i(ex_addr), .ex_mem_wdata_i(ex_wdata),
    .ex_w_reg_req_i(ex_wreq), .ex_w_reg_addr_i(ex_wrd), .ex_w_reg_data_i(ex_wdat),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(bus_be),
    .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata),
    .stall_req_o(stall), .mem_w_reg_req_o(wreq), .mem_w_reg_addr_o(waddr),
    .mem_w_reg_data_o(wdata), .fault_o(fault), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rd, wr; logic [2:0] op; logic [31:0] addr, wd, rdata; int k;
    logic wr_req; logic [4:0] rdst; logic [31:0] alu;
    logic [3:0] be; logic [31:0] bwd; logic exp_req; logic [31:0] exp_data; logic flt;
  } vec_t;
  vec_t v [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t t, input int n);
    int stalls;
    logic ok, mem;
    @(negedge clk);
    ex_valid = 1; ex_rd = t.rd; ex_wr = t.wr; ex_op = t.op; ex_addr = t.addr; ex_wdata = t.wd;
    ex_wreq = t.wr_req; ex_wrd = t.rdst; ex_wdat = t.alu; bus_ack = 0; bus_rdata = t.rdata;
    mem = t.rd | t.wr;
    #1 chk($sformatf("v%0d stall_t0", n), 32'(stall), 32'(mem & ~t.flt));
    if (mem && !t.flt) begin
      stalls = int'(stall);
      ok = 1;
      for (int i = 1; i <= t.k; i++) begin
        @(negedge clk);
        bus_ack = (i == t.k);
        #1 stalls += int'(stall);
        ok &= bus_req === 1 && bus_we === t.wr && bus_addr === {t.addr[31:2], 2'b00}
              && bus_be === t.be && bus_wdata === t.bwd;
      end
      chk($sformatf("v%0d stall_cycles", n), 32'(stalls), 32'(t.k));
      chk($sformatf("v%0d bus_fields", n), 32'(ok), 32'd1);
    end
    @(negedge clk);
    bus_ack = 0; ex_valid = 0;
    #1 chk($sformatf("v%0d wreq", n), 32'(wreq), 32'(t.exp_req));
    if (t.exp_req) begin
      chk($sformatf("v%0d waddr", n), 32'(waddr), 32'(t.rdst));
      chk($sformatf("v%0d wdata", n), wdata, t.exp_data);
    end
    chk($sformatf("v%0d fault", n), 32'(fault), 32'(t.flt));
    chk($sformatf("v%0d bus_req_after", n), 32'(bus_req), 32'd0);
    @(negedge clk);
    #1 chk($sformatf("v%0d idle_quiet", n), {29'd0, fault, tmo, wreq}, 32'd0);
  endtask

  initial begin
    logic ok;
    v[0]  = '{0,0,3'b000,32'h0,32'h0,32'h0,0, 1,5'd5,32'h1234, 4'b0000,32'h0, 1,32'h1234,0};
    v[1]  = '{1,0,3'b000,32'h1003,32'h11223344,32'h80FF0000,2, 1,5'd7,32'h0, 4'b1000,32'h44444444, 1,32'hFFFFFF80,0};
    v[2]  = '{1,0,3'b101,32'h2002,32'h0,32'hBEEF0000,1, 1,5'd8,32'h0, 4'b1100,32'h0, 1,32'h0000BEEF,0};
    v[3]  = '{0,1,3'b000,32'h3001,32'h123456AB,32'h0,4, 1,5'd9,32'h99, 4'b0010,32'hABABABAB, 0,32'h0,0};
    v[4]  = '{1,0,3'b010,32'h4000,32'h0,32'hDEADBEEF,1, 1,5'd10,32'h0, 4'b1111,32'h0, 1,32'hDEADBEEF,0};
    v[5]  = '{1,0,3'b001,32'h5000,32'h0,32'h12348001,3, 1,5'd11,32'h0, 4'b0011,32'h0, 1,32'hFFFF8001,0};
    v[6]  = '{1,0,3'b100,32'h6002,32'h0,32'h00F00000,2, 1,5'd12,32'h0, 4'b0100,32'h0, 1,32'h000000F0,0};
    v[7]  = '{0,1,3'b010,32'h7000,32'hCAFEF00D,32'h0,1, 1,5'd1,32'h0, 4'b1111,32'hCAFEF00D, 0,32'h0,0};
    v[8]  = '{0,1,3'b001,32'h7002,32'hFFFFBEEF,32'h0,2, 0,5'd0,32'h0, 4'b1100,32'hBEEFBEEF, 0,32'h0,0};
    v[9]  = '{1,0,3'b010,32'h4002,32'h0,32'h0,0, 1,5'd3,32'h77, 4'b0000,32'h0, 0,32'h0,1};
    v[10] = '{1,0,3'b011,32'h4000,32'h0,32'h0,0, 1,5'd3,32'h77, 4'b0000,32'h0, 0,32'h0,1};
    v[11] = '{1,1,3'b010,32'h0,32'h0,32'h0,0, 1,5'd3,32'h77, 4'b0000,32'h0, 0,32'h0,1};
    v[12] = '{1,0,3'b001,32'h1,32'h0,32'h0,0, 1,5'd3,32'h77, 4'b0000,32'h0, 0,32'h0,1};
    v[13] = '{1,0,3'b000,32'h0,32'h0,32'h0000007F,1, 0,5'd13,32'h0, 4'b0001,32'h0, 0,32'h0,0};
    v[14] = '{0,0,3'b000,32'h0,32'h0,32'h0,0, 0,5'd6,32'h55, 4'b0000,32'h0, 0,32'h0,0};
    v[15] = '{1,0,3'b000,32'h8002,32'h0,32'h00800000,1, 1,5'd14,32'h0, 4'b0100,32'h0, 1,32'hFFFFFF80,0};
    repeat (2) @(negedge clk);
    #1 chk("reset_ctrl", {27'd0, bus_req, stall, wreq, fault, tmo}, 32'd0);
    chk("reset_data", 32'(|{bus_we, bus_addr, bus_be, bus_wdata, waddr, wdata}), 32'd0);
    rst_n = 1;
    for (int i = 0; i < 16; i++) run(v[i], i);

    // timeout: no ack for TIMEOUT busy cycles
    @(negedge clk);
    ex_valid = 1; ex_rd = 1; ex_wr = 0; ex_op = 3'b010; ex_addr = 32'h100; ex_wreq = 1; bus_ack = 0;
    #1 chk("to_stall_t0", 32'(stall), 32'd1);
    ok = 1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      #1 ok &= bus_req === 1 && stall === (i < 4) && tmo === 0;
    end
    chk("to_busy_window", 32'(ok), 32'd1);
    @(negedge clk);
    ex_valid = 0;
    #1 chk("to_pulse", {29'd0, tmo, bus_req, wreq}, 32'b100);
    @(negedge clk);
    #1 chk("to_pulse_width", 32'(tmo), 32'd0);
    run(v[4], 100);

    // back-to-back: store accepted in the cycle after the load ack
    @(negedge clk);
    ex_valid = 1; ex_rd = 1; ex_wr = 0; ex_op = 3'b010; ex_addr = 32'h4000; ex_wreq = 1; ex_wrd = 5'd20;
    bus_rdata = 32'h55AA55AA;
    @(negedge clk);
    bus_ack = 1;
    @(negedge clk);
    bus_ack = 0; ex_rd = 0; ex_wr = 1; ex_addr = 32'h8000; ex_wdata = 32'h1;
    #1 chk("b2b_load_data", wdata, 32'h55AA55AA);
    chk("b2b_load_req", {26'd0, wreq, waddr}, {26'd0, 1'b1, 5'd20});
    chk("b2b_stall", 32'(stall), 32'd1);
    @(negedge clk);
    #1 chk("b2b_store_bus", {30'd0, bus_req, bus_we}, 32'b11);
    chk("b2b_store_addr", bus_addr, 32'h8000);
    bus_ack = 1;
    @(negedge clk);
    bus_ack = 0; ex_valid = 0;
    #1 chk("b2b_store_done", {30'd0, bus_req, wreq}, 32'd0);

    // asynchronous reset in the middle of a busy access
    @(negedge clk);
    ex_valid = 1; ex_rd = 1; ex_wr = 0; ex_op = 3'b010; ex_addr = 32'h200; ex_wreq = 1;
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("rst_mid_ctrl", {27'd0, bus_req, stall, wreq, fault, tmo}, 32'd0);
    @(negedge clk);
    ex_valid = 0; rst_n = 1;
    ok = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 ok &= {bus_req, wreq, fault, tmo} === 4'd0;
    end
    chk("rst_mid_quiet", 32'(ok), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory stage of the core pipeline: takes the EX/MEM-registered instruction, runs load/store transfers on the data bus with a request/acknowledge handshake, aligns and extends load data, and registers the resulting write-back request. Its registered `mem_w_reg_*` outputs feed the WB stage and the forwarding unit's memory-stage bypass port, so only completed, architecturally valid results appear there. It raises `stall_req_o` to hold upstream stages while a bus transfer is outstanding.

## Interface
- `TIMEOUT`, default 16: number of BUSY cycles without `bus_ack_i` before the access is abandoned; legal range 1..255.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid_i`  in  1  an EX/MEM instruction is present this cycle.
- `ex_mem_rd_i`  in  1  the instruction is a load.
- `ex_mem_wr_i`  in  1  the instruction is a store.
- `ex_mem_op_i`  in  3  funct3: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- `ex_mem_addr_i`  in  32  effective byte address.
- `ex_mem_wdata_i`  in  32  store data, with the datum in the low bits.
- `ex_w_reg_req_i`  in  1  write-back enable.
- `ex_w_reg_addr_i`  in  5  destination register.
- `ex_w_reg_data_i`  in  32  ALU result, used for non-memory instructions.
- `bus_req_o`  out  1  bus request.
- `bus_we_o`  out  1  1 = write.
- `bus_addr_o`  out  32  word-aligned address `{addr[31:2],2'b00}`.
- `bus_be_o`  out  4  byte enables.
- `bus_wdata_o`  out  32  replicated store data.
- `bus_ack_i`  in  1  transfer complete; read data valid in the same cycle.
- `bus_rdata_i`  in  32  read word.
- `stall_req_o`  out  1  hold the EX/MEM register and everything upstream.
- `mem_w_reg_req_o`  out  1  registered write-back enable.
- `mem_w_reg_addr_o`  out  5  registered destination register.
- `mem_w_reg_data_o`  out  32  registered write-back data.
- `fault_o`  out  1  one-cycle pulse: access fault (misaligned, illegal funct3, or both rd and wr set).
- `timeout_o`  out  1  one-cycle pulse: bus timeout.

## Operation
- **State machine:** two states, IDLE and BUSY. The request fields are latched into internal registers when an access is accepted. The BUSY cycle counter `cnt` is 8 bits.
- **IDLE, `ex_valid_i` = 0:** next edge writes `mem_w_reg_req_o` = 0.
- **IDLE, valid instruction with no memory access:** next edge registers the `ex_w_reg_*` inputs into the `mem_w_reg_*` outputs.
- **IDLE, valid memory instruction with a fault:**
  - Faults are: half access with `addr[0]` = 1; word access with `addr[1:0]` ≠ 0; funct3 011, 110 or 111; or `ex_mem_rd_i` and `ex_mem_wr_i` both 1.
  - No bus activity takes place.
  - Next edge writes `fault_o` = 1 and `mem_w_reg_req_o` = 0.
- **IDLE, valid memory instruction without a fault:**
  - `stall_req_o` = 1 combinationally in this cycle.
  - Next edge: latch the request, go to BUSY, `cnt` = 0, `mem_w_reg_req_o` = 0 (bubble to WB).
- **BUSY, bus outputs:** `bus_req_o` = 1 and all bus outputs are driven from the latched registers, held stable until ack or timeout.
- **BUSY, `stall_req_o`:** `stall_req_o` = ~`bus_ack_i` & ~(`cnt` == `TIMEOUT`-1).
- **BUSY, on ack:**
  - Next edge returns to IDLE.
  - Load: `mem_w_reg_req_o` = latched `req`, `mem_w_reg_addr_o` = latched `rd`, `mem_w_reg_data_o` = extracted data.
  - Store: `mem_w_reg_req_o` = 0, forced regardless of `ex_w_reg_req_i`.
- **BUSY, no ack and `cnt` == `TIMEOUT`-1:** next edge returns to IDLE with `timeout_o` = 1 and `mem_w_reg_req_o` = 0.
- **BUSY, no ack otherwise:** `cnt` increments and `mem_w_reg_req_o` stays 0.
- **Simultaneous ack and timeout:** ack wins.
- **Byte enables and write data:**
  - Byte: `bus_be_o` = 0001 << `addr[1:0]`, `bus_wdata_o` = {4{wdata[7:0]}}.
  - Half: `bus_be_o` = `addr[1]` ? 1100 : 0011, `bus_wdata_o` = {2{wdata[15:0]}}.
  - Word: `bus_be_o` = 1111, `bus_wdata_o` = wdata.
  - Loads drive the same byte-enable pattern.
- **Load data extraction (little-endian):**
  - Byte = `rdata[8*addr[1:0] +: 8]`.
  - Half = `rdata[16*addr[1] +: 16]`.
  - Signed ops sign-extend; 100 and 101 zero-extend.
- **Ignored input:** `bus_ack_i` is ignored in IDLE.

## Timing
- **Reset values:** all outputs 0, state IDLE, `cnt` = 0, latched fields 0.
  - Reset asserted mid-BUSY drops `bus_req_o` immediately (asynchronously); the access produces no write-back and no pulse.
- **Non-memory or faulting instruction:** 1-cycle latency, no stall.
- **Memory access accepted in cycle T:**
  - `bus_req_o` = 1 from T+1.
  - If ack arrives in cycle T+k (k ≥ 1), the outputs update at the end of T+k.
  - `stall_req_o` is high in cycles T..T+k-1.
  - Upstream advances at the end of T+k.
- **Upstream contract:** upstream holds `ex_*` stable while `stall_req_o` = 1. The block relies only on the values latched at acceptance.
- **Timeout:** with no ack, `timeout_o` asserts in cycle T+`TIMEOUT`+1 and `stall_req_o` drops in cycle T+`TIMEOUT`.
- **Pulse width:** `fault_o` and `timeout_o` are exactly one cycle wide.
- **Back-to-back accesses:** the memory instruction that follows an acked access is accepted in the next IDLE cycle, with no dead cycle.

## Test plan
- **Non-memory instruction:** `ex_valid_i`=1, no rd/wr, `ex_w_reg_addr_i`=5, data 0x1234 → next cycle `mem_w_reg_req_o`=1, addr 5, data 0x1234; `stall_req_o` never high.
- **Signed byte load (LB):**
  - Stimulus: addr 0x1003; ack one cycle after request with `rdata`=0x80FF_0000.
  - Bus: `bus_addr_o`=0x1000, `bus_be_o`=1000.
  - Result: `mem_w_reg_data_o`=0xFFFF_FF80.
  - Stall: high for exactly 2 cycles.
- **Unsigned half load (LHU):** addr 0x2002, `rdata`=0xBEEF_0000 → `mem_w_reg_data_o`=0x0000_BEEF.
- **Byte store (SB):**
  - Stimulus: addr 0x3001, `wdata`=0x0000_00AB, ack delayed 3 cycles.
  - Bus: `bus_we_o`=1, `bus_be_o`=0010, `bus_wdata_o`=0xABAB_ABAB, held stable.
  - Result: `mem_w_reg_req_o` stays 0; stall high for 4 cycles.
- **Faults:**
  - LW at 0x4002 → `fault_o` pulses, `bus_req_o` stays 0, no write-back.
  - funct3 = 011 → same response.
- **Timeout and reset:**
  - `TIMEOUT`=4 with no ack → `timeout_o` pulses once after 4 BUSY cycles, stall releases, the next op is accepted normally.
  - Second run: assert `rst_n` low mid-BUSY → all outputs 0 immediately.
